// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Multi-cycle control sequencer: fetches a 32-bit instruction into the
//   instruction register, then steps it through decode, execute, memory and
//   writeback while producing the register-file, ALU and data-memory strobes.
//   Owns the program counter, the retired-instruction counter and a
//   memory-ready watchdog.
//
// Ports
//   Clock, Reset_N       : clock, asynchronous active-low reset
//   Start                : begin execution (sampled in IDLE only)
//   IMem_*               : instruction fetch handshake (Req/Ready), address, data
//   Instruction_Reg      : latched instruction, feeds the decoder
//   Reg_Read_En, ALU_En  : one-cycle strobes in DECODE / EXECUTE
//   DMem_Req/Write/Ready : data memory handshake, Write = 1 for store
//   Reg_Write_En/Sel     : writeback strobe and source (0 = ALU, 1 = memory)
//   Busy, Halted, Error  : status decoded from state
//   Instr_Count          : retired-instruction count, wraps at 2^16
module instruction_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset_N,
  input  logic        Start,
  output logic [31:0] IMem_Addr,
  output logic        IMem_Req,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instruction_Reg,
  output logic        Reg_Read_En,
  output logic        ALU_En,
  output logic        DMem_Req,
  output logic        DMem_Write,
  input  logic        DMem_Ready,
  output logic        Reg_Write_En,
  output logic        Reg_Write_Sel,
  output logic        Busy,
  output logic        Halted,
  output logic        Error,
  output logic [15:0] Instr_Count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT, S_ERROR
  } state_e;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LOAD  = 6'b100010;
  localparam logic [5:0]  OP_STORE = 6'b100011;
  localparam logic [5:0]  OP_JUMP  = 6'b000010;
  localparam logic [5:0]  OP_HALT  = 6'b111111;
  localparam logic [31:0] PC_INC   = 32'(PC_STEP);
  // Last tolerated ready-low count; a further low cycle at this count times out.
  localparam logic [7:0]  WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic        sel_q, sel_d;
  logic [5:0]  opcode;

  assign opcode = ir_q[5:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        // Ready is tested first so it wins over an expiring watchdog.
        if (IMem_Ready) begin
          ir_d    = IMem_Data;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE, OP_LOAD, OP_STORE: state_d = S_EXECUTE;
          OP_JUMP: begin
            pc_d    = {4'b0000, ir_q[31:6], 2'b00};
            cnt_d   = cnt_q + 16'd1;
            wait_d  = '0;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            cnt_d   = cnt_q + 16'd1;
            state_d = S_HALT;
          end
          default: state_d = S_ERROR;
        endcase
      end
      S_EXECUTE: begin
        if (opcode == OP_RTYPE) begin
          sel_d   = 1'b0;
          state_d = S_WRITEBACK;
        end else begin
          wait_d  = '0;
          state_d = S_MEMORY;
        end
      end
      S_MEMORY: begin
        if (DMem_Ready) begin
          if (opcode == OP_STORE) begin
            pc_d    = pc_q + PC_INC;
            cnt_d   = cnt_q + 16'd1;
            wait_d  = '0;
            state_d = S_FETCH;
          end else begin
            sel_d   = 1'b1;
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + PC_INC;
        cnt_d   = cnt_q + 16'd1;
        wait_d  = '0;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      sel_q   <= sel_d;
    end
  end

  // All outputs come from registered state only.
  assign IMem_Addr       = pc_q;
  assign IMem_Req        = (state_q == S_FETCH);
  assign Instruction_Reg = ir_q;
  assign Reg_Read_En     = (state_q == S_DECODE);
  assign ALU_En          = (state_q == S_EXECUTE);
  assign DMem_Req        = (state_q == S_MEMORY);
  assign DMem_Write      = (state_q == S_MEMORY) && (opcode == OP_STORE);
  assign Reg_Write_En    = (state_q == S_WRITEBACK);
  assign Reg_Write_Sel   = sel_q;
  assign Busy            = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
  assign Halted          = (state_q == S_HALT);
  assign Error           = (state_q == S_ERROR);
  assign Instr_Count     = cnt_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer
//   Directed self-checking bench for instruction_sequencer (MEM_TIMEOUT = 4).
module tb_instruction_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_N;
  logic        Start;
  logic [31:0] IMem_Addr;
  logic        IMem_Req;
  logic        IMem_Ready;
  logic [31:0] IMem_Data;
  logic [31:0] Instruction_Reg;
  logic        Reg_Read_En;
  logic        ALU_En;
  logic        DMem_Req;
  logic        DMem_Write;
  logic        DMem_Ready;
  logic        Reg_Write_En;
  logic        Reg_Write_Sel;
  logic        Busy;
  logic        Halted;
  logic        Error;
  logic [15:0] Instr_Count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  instruction_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .PC_STEP    (4),
    .MEM_TIMEOUT(4)
  ) dut (
    .Clock          (Clock),
    .Reset_N        (Reset_N),
    .Start          (Start),
    .IMem_Addr      (IMem_Addr),
    .IMem_Req       (IMem_Req),
    .IMem_Ready     (IMem_Ready),
    .IMem_Data      (IMem_Data),
    .Instruction_Reg(Instruction_Reg),
    .Reg_Read_En    (Reg_Read_En),
    .ALU_En         (ALU_En),
    .DMem_Req       (DMem_Req),
    .DMem_Write     (DMem_Write),
    .DMem_Ready     (DMem_Ready),
    .Reg_Write_En   (Reg_Write_En),
    .Reg_Write_Sel  (Reg_Write_Sel),
    .Busy           (Busy),
    .Halted         (Halted),
    .Error          (Error),
    .Instr_Count    (Instr_Count)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Assumes the DUT sits in IDLE; leaves it in the first FETCH cycle.
  task automatic start_run();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_imem_req", 32'(IMem_Req), 32'd1);
  endtask

  // Assumes FETCH; holds ready low for 'delay' cycles, then accepts 'data'.
  task automatic fetch(input logic [31:0] data, input int unsigned delay);
    for (int unsigned i = 0; i < delay; i++) begin
      check("fetch_wait_req", 32'(IMem_Req), 32'd1);
      tick();
    end
    IMem_Ready = 1'b1;
    IMem_Data  = data;
    tick();
    IMem_Ready = 1'b0;
    IMem_Data  = '0;
  endtask

  task automatic do_reset();
    Reset_N = 1'b0;
    tick();
    Reset_N = 1'b1;
    tick();
  endtask

  initial begin
    Reset_N    = 1'b0;
    Start      = 1'b0;
    IMem_Ready = 1'b0;
    IMem_Data  = '0;
    DMem_Ready = 1'b0;
    #12;
    check("rst_pc",    IMem_Addr, 32'h0);
    check("rst_ir",    Instruction_Reg, 32'h0);
    check("rst_count", 32'(Instr_Count), 32'd0);
    check("rst_busy",  32'(Busy), 32'd0);
    check("rst_req",   32'(IMem_Req), 32'd0);
    check("rst_sel",   32'(Reg_Write_Sel), 32'd0);
    check("rst_err",   32'(Error), 32'd0);
    check("rst_halt",  32'(Halted), 32'd0);
    Reset_N = 1'b1;
    tick();
    check("idle_no_start", 32'(IMem_Req), 32'd0);

    // R-type at PC 0, ready immediately
    start_run();
    check("r_addr", IMem_Addr, 32'h0);
    fetch(32'h0000_0000, 0);
    check("r_dec_rd",  32'(Reg_Read_En), 32'd1);
    check("r_dec_alu", 32'(ALU_En), 32'd0);
    tick();
    check("r_ex_alu", 32'(ALU_En), 32'd1);
    check("r_ex_rd",  32'(Reg_Read_En), 32'd0);
    tick();
    check("r_wb_we",  32'(Reg_Write_En), 32'd1);
    check("r_wb_sel", 32'(Reg_Write_Sel), 32'd0);
    check("r_wb_cnt", 32'(Instr_Count), 32'd0);
    tick();
    check("r_next_addr", IMem_Addr, 32'h4);
    check("r_cnt",       32'(Instr_Count), 32'd1);
    check("r_we_off",    32'(Reg_Write_En), 32'd0);

    // Load at PC 4, DMem_Ready after 3 low cycles
    fetch(32'h8C43_0022, 0);
    check("ld_ir", Instruction_Reg, 32'h8C43_0022);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ld_dmem_req", 32'(DMem_Req), 32'd1);
      check("ld_dmem_wr",  32'(DMem_Write), 32'd0);
      DMem_Ready = (i == 3);
      tick();
    end
    DMem_Ready = 1'b0;
    check("ld_req_drop", 32'(DMem_Req), 32'd0);
    check("ld_wb_we",    32'(Reg_Write_En), 32'd1);
    check("ld_wb_sel",   32'(Reg_Write_Sel), 32'd1);
    tick();
    check("ld_addr",     IMem_Addr, 32'h8);
    check("ld_cnt",      32'(Instr_Count), 32'd2);
    check("ld_sel_hold", 32'(Reg_Write_Sel), 32'd1);

    // Jump 0x1002 -> target 0x100
    fetch(32'h0000_1002, 0);
    check("j_dec_alu", 32'(ALU_En), 32'd0);
    tick();
    check("j_addr",  IMem_Addr, 32'h100);
    check("j_cnt",   32'(Instr_Count), 32'd3);
    check("j_alu",   32'(ALU_En), 32'd0);
    check("j_we",    32'(Reg_Write_En), 32'd0);
    check("j_fetch", 32'(IMem_Req), 32'd1);

    // Store at 0x100, ready immediately
    fetch(32'h0000_0023, 0);
    tick();
    tick();
    check("st_req", 32'(DMem_Req), 32'd1);
    check("st_wr",  32'(DMem_Write), 32'd1);
    DMem_Ready = 1'b1;
    tick();
    DMem_Ready = 1'b0;
    check("st_addr",    IMem_Addr, 32'h104);
    check("st_cnt",     32'(Instr_Count), 32'd4);
    check("st_req_off", 32'(DMem_Req), 32'd0);
    check("st_we",      32'(Reg_Write_En), 32'd0);

    // Store at 0x104, reset asserted in MEMORY between clock edges
    fetch(32'h0000_0023, 0);
    tick();
    tick();
    check("st2_req", 32'(DMem_Req), 32'd1);
    #2;
    Reset_N = 1'b0;
    #1;
    check("arst_req",  32'(DMem_Req), 32'd0);
    check("arst_pc",   IMem_Addr, 32'h0);
    check("arst_cnt",  32'(Instr_Count), 32'd0);
    check("arst_busy", 32'(Busy), 32'd0);
    tick();
    Reset_N = 1'b1;
    tick();

    // Halt
    start_run();
    fetch(32'h0000_003F, 0);
    tick();
    check("h_halted", 32'(Halted), 32'd1);
    check("h_busy",   32'(Busy), 32'd0);
    check("h_cnt",    32'(Instr_Count), 32'd1);
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    check("h_stay",     32'(Halted), 32'd1);
    check("h_no_fetch", 32'(IMem_Req), 32'd0);
    do_reset();
    check("h_cleared", 32'(Halted), 32'd0);

    // R-type then illegal opcode 0x05
    start_run();
    fetch(32'h0000_0000, 0);
    tick();
    tick();
    tick();
    check("il_pre_cnt", 32'(Instr_Count), 32'd1);
    fetch(32'h0000_0005, 0);
    tick();
    check("il_err",  32'(Error), 32'd1);
    check("il_cnt",  32'(Instr_Count), 32'd1);
    check("il_busy", 32'(Busy), 32'd0);
    check("il_pc",   IMem_Addr, 32'h4);
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    check("il_stay",     32'(Error), 32'd1);
    check("il_no_fetch", 32'(IMem_Req), 32'd0);
    do_reset();

    // Fetch watchdog: four ready-low cycles -> ERROR
    start_run();
    for (int i = 0; i < 4; i++) begin
      check("to_no_err", 32'(Error), 32'd0);
      tick();
    end
    check("to_err",    32'(Error), 32'd1);
    check("to_no_req", 32'(IMem_Req), 32'd0);
    do_reset();

    // Ready on the 4th cycle wins over the watchdog
    start_run();
    fetch(32'h0000_003F, 3);
    check("tb_no_err", 32'(Error), 32'd0);
    check("tb_decode", 32'(Reg_Read_En), 32'd1);
    tick();
    check("tb_halted", 32'(Halted), 32'd1);
    do_reset();

    // Data-memory watchdog on a store
    start_run();
    fetch(32'h0000_0023, 0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("dto_req", 32'(DMem_Req), 32'd1);
      tick();
    end
    check("dto_err", 32'(Error), 32'd1);
    check("dto_req_off", 32'(DMem_Req), 32'd0);
    check("dto_cnt", 32'(Instr_Count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
